raster_engine: RTL and testbench
================================

# raster_engine

Parametrised successor to the 8x8 command processor. It accepts byte-serial drawing commands over a valid/ready handshake and keeps a WIDTH x HEIGHT x BPP framebuffer in flops. It executes clear, single-pixel and filled-rectangle commands, and streams the framebuffer out in raster order with frame and line sync on request. It sits directly under the TinyTapeout top, fed from `ui_in`, driving `uo_out`.

## Interface
- `WIDTH`, default 8: framebuffer columns, legal range 2..16.
- `HEIGHT`, default 8: framebuffer rows, legal range 2..16.
- `BPP`, default 4: bits per pixel, legal range 1..4.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  command byte present.
- `cmd_data`  in  8  command byte.
- `cmd_ready`  out  1  engine accepts a byte this cycle.
- `pixel_valid`  out  1  scanout pixel present.
- `pixel_data`  out  BPP  scanout pixel value.
- `frame_sync`  out  1  high with pixel (0,0) of a scanout.
- `line_sync`  out  1  high with pixel x=0 of every row during scanout.
- `busy`  out  1  state is FILL or SCAN.

## Operation
- **Byte transfer**: a byte moves on `cmd_valid & cmd_ready`.
- **Byte 0 layout**: `{op[3:0], color[3:0]}`. Color is truncated to `color[BPP-1:0]`.
- **Argument bytes**: each is `{x[3:0], y[3:0]}`.
- **Opcodes**:
  - 0 NOP: 1 byte, no effect.
  - 1 CLEAR: 1 byte. All pixels are set to color in one cycle.
  - 2 PIXEL: 2 bytes. Writes (x0,y0). No write if x0>=WIDTH or y0>=HEIGHT.
  - 3 RECT: 3 bytes. Fills the inclusive rectangle from (x0,y0) to (x1,y1).
    - x1 is clamped to WIDTH-1 and y1 to HEIGHT-1 before use.
    - The rectangle is empty if x0>x1 or y0>y1 after clamping.
  - 4 FRAME: 1 byte, starts a scanout.
  - 5..15: treated as NOP.
- **FSM states**: CMD, ARG1, ARG2, FILL, SCAN. Reset state is CMD.
  - CMD: on an accepted byte, go to ARG1 for PIXEL/RECT, SCAN for FRAME, else stay in CMD.
  - ARG1: on an accepted byte, latch x0,y0. PIXEL writes at this edge and returns to CMD. RECT goes to ARG2.
  - ARG2: on an accepted byte, latch x1,y1 and go to FILL with cursor (x0,y0).
  - FILL: writes one pixel per cycle, row-major. x runs x0..x1, then wraps to x0 and y increments. After (x1,y1), return to CMD.
    - An empty rectangle spends exactly one FILL cycle and writes nothing.
  - SCAN: outputs one pixel per cycle, row-major, from (0,0) to (WIDTH-1,HEIGHT-1), then returns to CMD.
- **cmd_ready**: 1 in CMD, ARG1 and ARG2. 0 in FILL and SCAN.
- **Scanout source**: SCAN outputs framebuffer contents as of the cycle each pixel is read. No writes occur during SCAN.
- **Coordinate widths**: cursor registers are 4 bits. Comparisons are unsigned, no wrap beyond the clamped bounds.

## Timing
- **Reset** (`rst_n`=0 at an edge): state=CMD, framebuffer all 0, `pixel_valid`=0, `pixel_data`=0, `frame_sync`=0, `line_sync`=0, `busy`=0.
  - `cmd_ready`=1 from the first cycle after reset is released.
- **Reset mid-operation**: aborts FILL or SCAN immediately and discards partially received commands. Pixels already written by FILL are cleared by the reset.
- **Write latency**: CLEAR and PIXEL results are visible one cycle after the accepting edge.
- **RECT duration**: FILL lasts max(1, (x1-x0+1)*(y1-y0+1)) cycles. `cmd_ready` returns to 1 in the cycle after the last FILL cycle.
- **SCAN outputs**:
  - `pixel_valid`, `pixel_data`, `frame_sync` and `line_sync` are registered.
  - The first pixel appears the cycle after FRAME is accepted, then WIDTH*HEIGHT consecutive cycles follow with no gaps.
  - `frame_sync` is a single-cycle pulse. `line_sync` pulses HEIGHT times.
- **After SCAN**: `pixel_valid`=0 and `cmd_ready`=1 in the cycle after the last pixel.
- **Back-to-back commands**: a new byte may be accepted in any cycle with `cmd_ready`=1, with no idle cycle required between commands.
- **Idle outputs**: `pixel_data` holds 0 whenever `pixel_valid`=0.

## Test plan
- **Reset then FRAME** (0x40), default params -> 64 cycles of `pixel_valid`=1 with data 0. `frame_sync` on cycle 1 only, `line_sync` on cycles 1,9,...,57. Then `cmd_ready`=1.
- **CLEAR then PIXEL then FRAME**: bytes 0x1A, then 0x25,0x23, then 0x40 -> all pixels 0xA except (x=2,y=3)=0x5, which appears at stream index 26.
- **RECT with busy check**: bytes 0x37,0x11,0x32 -> `busy`=1 and `cmd_ready`=0 for exactly 6 cycles. Scanout then shows 7 at x=1..3, y=1..2 and 0 elsewhere.
- **Clipping and empty**:
  - RECT 0x3F,0x66,0xFF -> clamped to (6..7,6..7), 4 FILL cycles.
  - RECT 0x33,0x50,0x20 -> 1 FILL cycle, no change.
  - PIXEL 0x29,0x90 -> no write.
- **Reset mid-SCAN and mid-RECT**: assert `rst_n`=0 on scan pixel 10 -> next cycle all outputs 0 and framebuffer 0. A subsequent FRAME streams all zeros.
- **Parameter sweep**: WIDTH=16, HEIGHT=4, BPP=2. CLEAR 0x13, then FRAME -> 64 pixels of value 3 with `line_sync` every 16 cycles. Unknown op 0xE0 is accepted as a NOP.

Source files
------------

// File: rtl/raster_engine.sv
// raster_engine: byte-serial drawing command processor with a WIDTH x HEIGHT x BPP
// flop framebuffer and raster-order scanout.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   cmd_valid    in   command byte present
//   cmd_data     in   command byte ({op,color} or {x,y})
//   cmd_ready    out  engine accepts a byte this cycle (CMD/ARG1/ARG2)
//   pixel_valid  out  scanout pixel present (registered)
//   pixel_data   out  scanout pixel value, 0 when idle (registered)
//   frame_sync   out  high with pixel (0,0) of a scanout (registered)
//   line_sync    out  high with pixel x=0 of each row (registered)
//   busy         out  FILL or SCAN in progress
module raster_engine #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter int unsigned BPP    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    input  logic [7:0]     cmd_data,
    output logic           cmd_ready,
    output logic           pixel_valid,
    output logic [BPP-1:0] pixel_data,
    output logic           frame_sync,
    output logic           line_sync,
    output logic           busy
);

    localparam logic [3:0] XMax = 4'(WIDTH - 1);
    localparam logic [3:0] YMax = 4'(HEIGHT - 1);

    typedef enum logic [2:0] {StCmd, StArg1, StArg2, StFill, StScan} state_t;

    state_t         r_state;
    logic [BPP-1:0] r_fb [HEIGHT][WIDTH];
    logic [BPP-1:0] r_color;
    logic           r_is_rect;
    logic           r_empty;
    logic           r_scan_end;
    logic [3:0]     r_x0, r_y0, r_x1, r_y1, r_cx, r_cy;
    logic           r_pixel_valid, r_frame_sync, r_line_sync;
    logic [BPP-1:0] r_pixel_data;

    logic           w_acc;
    logic [3:0]     w_op, w_ax, w_ay, w_x1c, w_y1c;
    logic [BPP-1:0] w_rd;
    logic           w_clear, w_we;
    logic [3:0]     w_wx, w_wy;

    assign cmd_ready   = (r_state == StCmd) || (r_state == StArg1) || (r_state == StArg2);
    assign busy        = (r_state == StFill) || (r_state == StScan);
    assign pixel_valid = r_pixel_valid;
    assign pixel_data  = r_pixel_data;
    assign frame_sync  = r_frame_sync;
    assign line_sync   = r_line_sync;

    assign w_acc = cmd_valid & cmd_ready;
    assign w_op  = cmd_data[7:4];
    assign w_ax  = cmd_data[7:4];
    assign w_ay  = cmd_data[3:0];
    assign w_x1c = (w_ax > XMax) ? XMax : w_ax;
    assign w_y1c = (w_ay > YMax) ? YMax : w_ay;

    // Scanout read mux at the cursor.
    always_comb begin
        w_rd = '0;
        for (int y = 0; y < int'(HEIGHT); y++) begin
            for (int x = 0; x < int'(WIDTH); x++) begin
                if (r_cx == 4'(x) && r_cy == 4'(y)) w_rd = r_fb[y][x];
            end
        end
    end

    // Framebuffer write port: CLEAR hits all pixels, PIXEL and FILL hit one.
    always_comb begin
        w_clear = 1'b0;
        w_we    = 1'b0;
        w_wx    = r_cx;
        w_wy    = r_cy;
        if (r_state == StCmd && w_acc && w_op == 4'd1) w_clear = 1'b1;
        if (r_state == StArg1 && w_acc && !r_is_rect && w_ax <= XMax && w_ay <= YMax) begin
            w_we = 1'b1;
            w_wx = w_ax;
            w_wy = w_ay;
        end
        if (r_state == StFill && !r_empty) w_we = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int y = 0; y < int'(HEIGHT); y++) begin
            for (int x = 0; x < int'(WIDTH); x++) begin
                if (!rst_n) begin
                    r_fb[y][x] <= '0;
                end else if (w_clear) begin
                    r_fb[y][x] <= cmd_data[BPP-1:0];
                end else if (w_we && w_wx == 4'(x) && w_wy == 4'(y)) begin
                    r_fb[y][x] <= r_color;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StCmd;
            r_color       <= '0;
            r_is_rect     <= 1'b0;
            r_empty       <= 1'b0;
            r_scan_end    <= 1'b0;
            r_x0          <= '0;
            r_y0          <= '0;
            r_x1          <= '0;
            r_y1          <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= '0;
            r_frame_sync  <= 1'b0;
            r_line_sync   <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= '0;
            r_frame_sync  <= 1'b0;
            r_line_sync   <= 1'b0;
            case (r_state)
                StCmd: begin
                    if (w_acc) begin
                        r_color <= cmd_data[BPP-1:0];
                        case (w_op)
                            4'd2, 4'd3: begin
                                r_is_rect <= (w_op == 4'd3);
                                r_state   <= StArg1;
                            end
                            4'd4: begin
                                // Pixel (0,0) is emitted at the accepting edge so the
                                // stream starts the very next cycle.
                                r_pixel_valid <= 1'b1;
                                r_pixel_data  <= r_fb[0][0];
                                r_frame_sync  <= 1'b1;
                                r_line_sync   <= 1'b1;
                                r_cx          <= 4'd1;
                                r_cy          <= 4'd0;
                                r_scan_end    <= 1'b0;
                                r_state       <= StScan;
                            end
                            default: ;
                        endcase
                    end
                end
                StArg1: begin
                    if (w_acc) begin
                        r_x0    <= w_ax;
                        r_y0    <= w_ay;
                        r_state <= r_is_rect ? StArg2 : StCmd;
                    end
                end
                StArg2: begin
                    if (w_acc) begin
                        r_x1    <= w_x1c;
                        r_y1    <= w_y1c;
                        r_cx    <= r_x0;
                        r_cy    <= r_y0;
                        // x0 beyond the array is always > clamped x1, so it is empty too.
                        r_empty <= (r_x0 > w_x1c) || (r_y0 > w_y1c);
                        r_state <= StFill;
                    end
                end
                StFill: begin
                    if (r_empty || (r_cx == r_x1 && r_cy == r_y1)) begin
                        r_state <= StCmd;
                    end else if (r_cx == r_x1) begin
                        r_cx <= r_x0;
                        r_cy <= r_cy + 4'd1;
                    end else begin
                        r_cx <= r_cx + 4'd1;
                    end
                end
                StScan: begin
                    if (r_scan_end) begin
                        r_state <= StCmd;
                    end else begin
                        r_pixel_valid <= 1'b1;
                        r_pixel_data  <= w_rd;
                        r_line_sync   <= (r_cx == 4'd0);
                        r_scan_end    <= (r_cx == XMax) && (r_cy == YMax);
                        if (r_cx == XMax) begin
                            r_cx <= 4'd0;
                            r_cy <= r_cy + 4'd1;
                        end else begin
                            r_cx <= r_cx + 4'd1;
                        end
                    end
                end
                default: r_state <= StCmd;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_engine.sv
module tb_raster_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_valid_b;
    logic [7:0] cmd_data, cmd_data_b;
    logic       cmd_ready, pixel_valid, frame_sync, line_sync, busy;
    logic [3:0] pixel_data;
    logic       cmd_ready_b, pixel_valid_b, frame_sync_b, line_sync_b, busy_b;
    logic [1:0] pixel_data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fill;
    logic [3:0] exp_img [64];

    always #5 clk = ~clk;

    raster_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .frame_sync  (frame_sync),
        .line_sync   (line_sync),
        .busy        (busy)
    );

    raster_engine #(.WIDTH(16), .HEIGHT(4), .BPP(2)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid_b),
        .cmd_data    (cmd_data_b),
        .cmd_ready   (cmd_ready_b),
        .pixel_valid (pixel_valid_b),
        .pixel_data  (pixel_data_b),
        .frame_sync  (frame_sync_b),
        .line_sync   (line_sync_b),
        .busy        (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_a_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic send_b(input logic [7:0] b);
        int n = 0;
        while (!cmd_ready_b && n < 200) begin
            tick();
            n++;
        end
        check("send_b_ready", 32'(cmd_ready_b), 32'd1);
        cmd_valid_b = 1'b1;
        cmd_data_b  = b;
        tick();
        cmd_valid_b = 1'b0;
        cmd_data_b  = 8'h00;
    endtask

    task automatic set_rect(input int x0, input int y0, input int x1, input int y1,
                            input logic [3:0] c);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) exp_img[y * 8 + x] = c;
    endtask

    // Counts busy cycles after the last RECT byte; cmd_ready must be low throughout.
    task automatic count_fill(output int n);
        n = 0;
        while (busy && n < 300) begin
            check("fill_ready_low", {30'd0, busy, cmd_ready}, 32'b10);
            n++;
            tick();
        end
        check("fill_done_ready", {30'd0, busy, cmd_ready}, 32'b01);
    endtask

    task automatic scan_a(input string tag);
        send_a(8'h40);
        for (int i = 0; i < 64; i++) begin
            check(tag, {24'd0, busy, pixel_valid, frame_sync, line_sync, pixel_data},
                  {24'd0, 1'b1, 1'b1, (i == 0), (i % 8 == 0), exp_img[i]});
            tick();
        end
        check({tag, "_end"}, {24'd0, pixel_valid, frame_sync, line_sync, pixel_data,
                               cmd_ready, busy}, 32'b10);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = 8'h00;
        cmd_valid_b = 1'b0;
        cmd_data_b  = 8'h00;
        repeat (2) tick();
        check("reset_outputs", {26'd0, pixel_valid, frame_sync, line_sync, pixel_data, busy},
              32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Reset then FRAME: all zeros
        set_rect(0, 0, 7, 7, 4'h0);
        scan_a("scan_zero");

        // CLEAR A, PIXEL (2,3)=5, FRAME
        send_a(8'h1A);
        send_a(8'h25);
        send_a(8'h23);
        set_rect(0, 0, 7, 7, 4'hA);
        exp_img[26] = 4'h5;
        scan_a("scan_clear_pixel");

        // RECT color 7, (1,1)..(3,2), six FILL cycles
        send_a(8'h10);
        send_a(8'h37);
        send_a(8'h11);
        send_a(8'h32);
        count_fill(n_fill);
        check("rect_fill_cycles", 32'(n_fill), 32'd6);
        set_rect(0, 0, 7, 7, 4'h0);
        set_rect(1, 1, 3, 2, 4'h7);
        scan_a("scan_rect");

        // Clamped RECT (6,6)..(15,15) -> (6..7,6..7)
        send_a(8'h3F);
        send_a(8'h66);
        send_a(8'hFF);
        count_fill(n_fill);
        check("clamp_fill_cycles", 32'(n_fill), 32'd4);
        set_rect(6, 6, 7, 7, 4'hF);

        // Empty RECT x0=5 > x1=2
        send_a(8'h33);
        send_a(8'h50);
        send_a(8'h20);
        count_fill(n_fill);
        check("empty_fill_cycles", 32'(n_fill), 32'd1);

        // Out-of-range PIXEL, then unknown opcode as NOP
        send_a(8'h29);
        send_a(8'h90);
        check("pixel_oob_idle", {30'd0, busy, cmd_ready}, 32'b01);
        send_a(8'hE0);
        check("nop_idle", {30'd0, busy, cmd_ready}, 32'b01);
        scan_a("scan_clip");

        // Reset mid-RECT clears partial fill
        send_a(8'h31);
        send_a(8'h00);
        send_a(8'h77);
        repeat (3) tick();
        check("mid_rect_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rect_reset", {30'd0, busy, pixel_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        set_rect(0, 0, 7, 7, 4'h0);
        scan_a("scan_after_rect_reset");

        // Reset on scan pixel 10
        send_a(8'h1F);
        send_a(8'h40);
        repeat (10) tick();
        check("mid_scan_pixel10", {27'd0, pixel_valid, pixel_data}, {27'd0, 1'b1, 4'hF});
        rst_n = 1'b0;
        tick();
        check("mid_scan_reset", {26'd0, pixel_valid, frame_sync, line_sync, pixel_data, busy},
              32'd0);
        rst_n = 1'b1;
        tick();
        scan_a("scan_after_scan_reset");

        // Parameter sweep instance: 16x4x2
        send_b(8'h13);
        send_b(8'hE0);
        check("b_nop_idle", {30'd0, busy_b, cmd_ready_b}, 32'b01);
        send_b(8'h40);
        for (int i = 0; i < 64; i++) begin
            check("scan_b", {26'd0, busy_b, pixel_valid_b, frame_sync_b, line_sync_b,
                             pixel_data_b},
                  {26'd0, 1'b1, 1'b1, (i == 0), (i % 16 == 0), 2'd3});
            tick();
        end
        check("scan_b_end", {28'd0, pixel_valid_b, pixel_data_b, cmd_ready_b}, 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
